// File: rtl/beetle_antenna_gen.sv
//==============================================================================
// Module      : beetle_antenna_gen
// Description : Beetle-antenna search position generator. For a request
//               (dir, pos, sense) produces pos_l = pos + off and
//               pos_r = pos - off per lane, where off = (dir*sense) >>> FRAC.
//               Lanes are processed one per cycle through a single shared
//               multiplier, with one register stage between the multiply
//               and the add/subtract.
//               Optional feature: define BAS_ANTENNA_SAT_EN to saturate
//               out-of-range lane results instead of wrapping them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module beetle_antenna_gen #(
    parameter int DIM     = 2,
    parameter int POS_W   = 16,
    parameter int DIR_W   = 9,
    parameter int SENSE_W = 14,
    parameter int FRAC    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIM*DIR_W-1:0]   dir,
    input  logic [DIM*POS_W-1:0]   pos,
    input  logic [SENSE_W-1:0]     sense,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIM*POS_W-1:0]   pos_l,
    output logic [DIM*POS_W-1:0]   pos_r,
    output logic                   ovf
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_PROD_W = DIR_W + SENSE_W;
    localparam int c_EXT_W  = POS_W + 1;
    localparam int c_IDX_W  = (DIM > 1) ? $clog2(DIM) : 1;
    // Counter runs 0..DIM: value k multiplies lane k and writes back lane k-1.
    localparam int c_CNT_W  = $clog2(DIM + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(DIM);

    localparam logic signed [POS_W-1:0] c_POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] c_POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [DIM*DIR_W-1:0]      r_dir;
    logic [DIM*POS_W-1:0]      r_pos;
    logic [SENSE_W-1:0]        r_sense_eff;
    logic signed [c_EXT_W-1:0] r_off;
    logic [DIM*POS_W-1:0]      r_pos_l;
    logic [DIM*POS_W-1:0]      r_pos_r;
    logic                      r_ovf;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                      w_accept;
    logic                      w_calc;
    logic                      w_in_ready;
    logic                      w_out_valid;
    logic [c_IDX_W-1:0]        w_mul_idx;
    logic [c_CNT_W-1:0]        w_wb_cnt;
    logic [c_IDX_W-1:0]        w_wb_idx;
    logic                      w_wb_en;
    logic [DIR_W-1:0]          w_dir_arr [DIM];
    logic [POS_W-1:0]          w_pos_arr [DIM];
    logic [DIR_W-1:0]          w_dir_lane;
    logic [c_PROD_W-1:0]       w_dir_x;
    logic [c_PROD_W-1:0]       w_sense_x;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_shr;
    logic signed [c_EXT_W-1:0] w_off;
    logic [POS_W-1:0]          w_pos_wb;
    logic signed [c_EXT_W-1:0] w_pos_x;
    logic signed [c_EXT_W-1:0] w_sum;
    logic signed [c_EXT_W-1:0] w_dif;
    logic                      w_ovf_l;
    logic                      w_ovf_r;
    logic [POS_W-1:0]          w_l_nar;
    logic [POS_W-1:0]          w_r_nar;

    // Lane views of the captured request vectors
    genvar gi;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_lane
            assign w_dir_arr[gi] = r_dir[gi*DIR_W +: DIR_W];
            assign w_pos_arr[gi] = r_pos[gi*POS_W +: POS_W];
        end
    endgenerate

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_calc   = (r_state == S_CALC);

    // Multiply-stage lane; the final count only drains the write-back stage
    assign w_mul_idx  = (r_cnt < c_LAST_CNT) ? r_cnt[c_IDX_W-1:0] : '0;
    assign w_dir_lane = w_dir_arr[w_mul_idx];

    // Shared signed multiplier; sense_eff is never negative so it zero-extends
    assign w_dir_x   = {{SENSE_W{w_dir_lane[DIR_W-1]}}, w_dir_lane};
    assign w_sense_x = {{DIR_W{1'b0}}, r_sense_eff};
    assign w_prod    = $signed(w_dir_x) * $signed(w_sense_x);
    assign w_shr     = w_prod >>> FRAC;

    // Bring the shifted product to the POS_W+1 evaluation width
    generate
        if (c_PROD_W >= c_EXT_W) begin : g_off_trunc
            assign w_off = w_shr[c_EXT_W-1:0];
        end else begin : g_off_ext
            assign w_off = {{(c_EXT_W-c_PROD_W){w_shr[c_PROD_W-1]}}, w_shr};
        end
    endgenerate

    // Write-back stage works on the lane multiplied in the previous cycle
    assign w_wb_cnt = r_cnt - 1'b1;
    assign w_wb_idx = w_wb_cnt[c_IDX_W-1:0];
    assign w_wb_en  = w_calc && (r_cnt != '0);
    assign w_pos_wb = w_pos_arr[w_wb_idx];
    assign w_pos_x  = {w_pos_wb[POS_W-1], w_pos_wb};
    assign w_sum    = w_pos_x + r_off;
    assign w_dif    = w_pos_x - r_off;
    assign w_ovf_l  = w_sum[POS_W] ^ w_sum[POS_W-1];
    assign w_ovf_r  = w_dif[POS_W] ^ w_dif[POS_W-1];

    // Narrow each POS_W+1 result back to POS_W (saturate or wrap)
    always_comb begin
        w_l_nar = w_sum[POS_W-1:0];
        w_r_nar = w_dif[POS_W-1:0];
`ifdef BAS_ANTENNA_SAT_EN
        if (w_ovf_l) begin
            w_l_nar = w_sum[POS_W] ? c_POS_MIN : c_POS_MAX;
        end
        if (w_ovf_r) begin
            w_r_nar = w_dif[POS_W] ? c_POS_MIN : c_POS_MAX;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)               w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == c_LAST_CNT)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)              w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Request capture, lane sequencing, result write-back and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_dir       <= '0;
            r_pos       <= '0;
            r_sense_eff <= '0;
            r_off       <= '0;
            r_pos_l     <= '0;
            r_pos_r     <= '0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            r_dir       <= dir;
            r_pos       <= pos;
            r_sense_eff <= sense[SENSE_W-1] ? '0 : sense;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
        end else if (w_calc) begin
            r_off <= w_off;
            if (w_wb_en) begin
                for (int i = 0; i < DIM; i++) begin
                    if (w_wb_idx == c_IDX_W'(i)) begin
                        r_pos_l[i*POS_W +: POS_W] <= w_l_nar;
                        r_pos_r[i*POS_W +: POS_W] <= w_r_nar;
                    end
                end
                r_ovf <= r_ovf | w_ovf_l | w_ovf_r;
            end
            r_cnt <= (r_cnt == c_LAST_CNT) ? '0 : r_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign pos_l     = r_pos_l;
    assign pos_r     = r_pos_r;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire
